fetch_queue: RTL and testbench

Parametrised instruction fetch queue between iFetch and iDecode. It buffers up to DEPTH {pc, instruction} pairs so fetch can run ahead of a stalled decode, and drops all buffered entries on a taken branch. A valid/ready handshake on both sides replaces the fixed delayed-clock coupling between fetch and decode. An optional same-cycle bypass removes the one-cycle latency through an empty queue.

---
 rtl/fetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry {pc, instr} FIFO between fetch and decode with flush-on-branch.
// Optional same-cycle empty-queue bypass when FETCHQ_BYPASS_EN is defined.
module fetch_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PC_W    = 64,
   parameter int unsigned INSTR_W = 32
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_flush,
   input  logic                         i_enq_valid,
   output logic                         o_enq_ready,
   input  logic [PC_W-1:0]              i_enq_pc,
   input  logic [INSTR_W-1:0]           i_enq_instr,
   output logic                         o_deq_valid,
   input  logic                         i_deq_ready,
   output logic [PC_W-1:0]              o_deq_pc,
   output logic [INSTR_W-1:0]           o_deq_instr,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic [15:0]                  o_drop_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [PC_W-1:0]    r_pc_mem    [DEPTH];
   logic [INSTR_W-1:0] r_instr_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [15:0]        r_drop_cnt;

   logic               w_empty;
   logic               w_enq_ready;
   logic               w_bypass;
   logic               w_enq;
   logic               w_deq_valid;
   logic               w_deq;
   logic               w_wr;
   logic               w_rd;
   logic [CNT_W-1:0]   w_drop_add;
   logic [16:0]        w_drop_sum;
   logic [15:0]        w_drop_next;

   assign w_empty     = (r_count == '0);
   assign w_enq_ready = (r_count < CNT_W'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
   assign w_bypass = w_empty && i_enq_valid && !i_flush;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_enq       = i_enq_valid && w_enq_ready && !i_flush;
   assign w_deq_valid = !w_empty || w_bypass;
   assign w_deq       = w_deq_valid && i_deq_ready;
   // A bypassed entry consumed in the same cycle never touches storage
   assign w_wr        = w_enq && !(w_bypass && i_deq_ready);
   assign w_rd        = w_deq && !w_bypass;

   assign w_drop_add  = r_count - CNT_W'(w_deq);
   assign w_drop_sum  = 17'(r_drop_cnt) + 17'(w_drop_add);
   assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

   // Head read: bypass data first, stored head otherwise, zero when nothing is valid
   always_comb begin
      o_deq_pc    = '0;
      o_deq_instr = '0;
      if (w_bypass) begin
         o_deq_pc    = i_enq_pc;
         o_deq_instr = i_enq_instr;
      end else if (!w_empty) begin
         o_deq_pc    = r_pc_mem[r_rd_ptr];
         o_deq_instr = r_instr_mem[r_rd_ptr];
      end
   end

   assign o_enq_ready = w_enq_ready;
   assign o_deq_valid = w_deq_valid;
   assign o_count     = r_count;
   assign o_drop_cnt  = r_drop_cnt;

   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_pc_mem[r_wr_ptr]    <= i_enq_pc;
         r_instr_mem[r_wr_ptr] <= i_enq_instr;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop_cnt <= '0;
      end else if (i_flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop_cnt <= w_drop_next;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): vector table plus hand sequences for wrap, reset and bypass.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        enq_valid;
   logic        enq_ready;
   logic [63:0] enq_pc;
   logic [31:0] enq_instr;
   logic        deq_valid;
   logic        deq_ready;
   logic [63:0] deq_pc;
   logic [31:0] deq_instr;
   logic [2:0]  count;
   logic [15:0] drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(4), .PC_W(64), .INSTR_W(32)) dut (
      .i_clk(clk), .i_reset(rst), .i_flush(flush),
      .i_enq_valid(enq_valid), .o_enq_ready(enq_ready),
      .i_enq_pc(enq_pc), .i_enq_instr(enq_instr),
      .o_deq_valid(deq_valid), .i_deq_ready(deq_ready),
      .o_deq_pc(deq_pc), .o_deq_instr(deq_instr),
      .o_count(count), .o_drop_cnt(drop_cnt)
   );

   typedef struct {
      logic        flush;
      logic        ev;
      logic [63:0] pc;
      logic [31:0] instr;
      logic        dr;
      logic        er;
      logic        dv;
      logic [63:0] dpc;
      logic [31:0] dinstr;
      logic [2:0]  cnt;
      logic [15:0] drop;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl [NV];

   function automatic vec_t mk(logic f, logic ev, logic [63:0] pc, logic [31:0] in, logic dr,
                               logic er, logic dv, logic [63:0] dpc, logic [31:0] din,
                               logic [2:0] cnt, logic [15:0] drop);
      vec_t v;
      v.flush = f;  v.ev = ev;  v.pc = pc;  v.instr = in;  v.dr = dr;
      v.er = er;  v.dv = dv;  v.dpc = dpc;  v.dinstr = din;  v.cnt = cnt;  v.drop = drop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive inputs just after the falling edge and let them settle before checking
   task automatic drive(input logic f, input logic ev, input logic [63:0] pc,
                        input logic [31:0] in, input logic dr);
      @(negedge clk);
      flush = f;  enq_valid = ev;  enq_pc = pc;  enq_instr = in;  deq_ready = dr;
      #1;
   endtask

   initial begin
      logic        e_dv;
      logic [63:0] e_pc;
      logic [31:0] e_in;

      rst = 1'b1;  flush = 1'b0;  enq_valid = 1'b0;  enq_pc = '0;  enq_instr = '0;  deq_ready = 1'b0;

      // Columns: flush ev pc instr dr | er dv dpc dinstr cnt drop (values seen before the edge)
      tbl[0]  = mk(0,1,64'h0,  32'hF84402C9,0, 1,0,64'h0,  32'h0,       3'd0,16'd0);
      tbl[1]  = mk(0,1,64'h4,  32'h8B09026A,0, 1,1,64'h0,  32'hF84402C9,3'd1,16'd0);
      tbl[2]  = mk(0,1,64'h8,  32'hCB0A028B,0, 1,1,64'h0,  32'hF84402C9,3'd2,16'd0);
      tbl[3]  = mk(0,0,64'h0,  32'h0,       0, 1,1,64'h0,  32'hF84402C9,3'd3,16'd0);
      tbl[4]  = mk(0,0,64'h0,  32'h0,       1, 1,1,64'h0,  32'hF84402C9,3'd3,16'd0);
      tbl[5]  = mk(0,0,64'h0,  32'h0,       1, 1,1,64'h4,  32'h8B09026A,3'd2,16'd0);
      tbl[6]  = mk(0,0,64'h0,  32'h0,       1, 1,1,64'h8,  32'hCB0A028B,3'd1,16'd0);
      tbl[7]  = mk(0,0,64'h0,  32'h0,       0, 1,0,64'h0,  32'h0,       3'd0,16'd0);
      tbl[8]  = mk(0,1,64'h100,32'hA0,      0, 1,0,64'h0,  32'h0,       3'd0,16'd0);
      tbl[9]  = mk(0,1,64'h104,32'hA1,      0, 1,1,64'h100,32'hA0,      3'd1,16'd0);
      tbl[10] = mk(0,1,64'h108,32'hA2,      0, 1,1,64'h100,32'hA0,      3'd2,16'd0);
      tbl[11] = mk(0,1,64'h10C,32'hA3,      0, 1,1,64'h100,32'hA0,      3'd3,16'd0);
      tbl[12] = mk(0,1,64'h110,32'hA4,      0, 0,1,64'h100,32'hA0,      3'd4,16'd0);
      tbl[13] = mk(0,1,64'h110,32'hA4,      1, 0,1,64'h100,32'hA0,      3'd4,16'd0);
      tbl[14] = mk(0,0,64'h0,  32'h0,       0, 1,1,64'h104,32'hA1,      3'd3,16'd0);
      tbl[15] = mk(0,0,64'h0,  32'h0,       1, 1,1,64'h104,32'hA1,      3'd3,16'd0);
      tbl[16] = mk(0,0,64'h0,  32'h0,       1, 1,1,64'h108,32'hA2,      3'd2,16'd0);
      tbl[17] = mk(0,0,64'h0,  32'h0,       1, 1,1,64'h10C,32'hA3,      3'd1,16'd0);
      tbl[18] = mk(0,0,64'h0,  32'h0,       0, 1,0,64'h0,  32'h0,       3'd0,16'd0);
      tbl[19] = mk(0,1,64'h0,  32'h11111111,0, 1,0,64'h0,  32'h0,       3'd0,16'd0);
      tbl[20] = mk(0,1,64'h4,  32'h22222222,0, 1,1,64'h0,  32'h11111111,3'd1,16'd0);
      tbl[21] = mk(0,1,64'h8,  32'h33333333,0, 1,1,64'h0,  32'h11111111,3'd2,16'd0);
      tbl[22] = mk(1,1,64'hC,  32'hF80602CB,1, 1,1,64'h0,  32'h11111111,3'd3,16'd0);
      tbl[23] = mk(0,0,64'h0,  32'h0,       0, 1,0,64'h0,  32'h0,       3'd0,16'd2);
      tbl[24] = mk(0,1,64'h40, 32'h44,      0, 1,0,64'h0,  32'h0,       3'd0,16'd2);
      tbl[25] = mk(0,1,64'h44, 32'h55,      0, 1,1,64'h40, 32'h44,      3'd1,16'd2);
      tbl[26] = mk(0,0,64'h0,  32'h0,       0, 1,1,64'h40, 32'h44,      3'd2,16'd2);

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_enq_ready", 64'(enq_ready), 64'd1);
      chk("reset_deq_valid", 64'(deq_valid), 64'd0);
      chk("reset_deq_pc",    deq_pc,         64'd0);
      chk("reset_deq_instr", 64'(deq_instr), 64'd0);
      chk("reset_count",     64'(count),     64'd0);
      chk("reset_drop_cnt",  64'(drop_cnt),  64'd0);

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].flush, tbl[i].ev, tbl[i].pc, tbl[i].instr, tbl[i].dr);
         e_dv = tbl[i].dv;  e_pc = tbl[i].dpc;  e_in = tbl[i].dinstr;
`ifdef FETCHQ_BYPASS_EN
         if (tbl[i].cnt == 3'd0 && tbl[i].ev && !tbl[i].flush) begin
            e_dv = 1'b1;  e_pc = tbl[i].pc;  e_in = tbl[i].instr;
         end
`endif
         chk($sformatf("vec%0d_enq_ready", i), 64'(enq_ready), 64'(tbl[i].er));
         chk($sformatf("vec%0d_deq_valid", i), 64'(deq_valid), 64'(e_dv));
         chk($sformatf("vec%0d_deq_pc", i),    deq_pc,         e_pc);
         chk($sformatf("vec%0d_deq_instr", i), 64'(deq_instr), 64'(e_in));
         chk($sformatf("vec%0d_count", i),     64'(count),     64'(tbl[i].cnt));
         chk($sformatf("vec%0d_drop_cnt", i),  64'(drop_cnt),  64'(tbl[i].drop));
      end

      // Asynchronous reset between edges with two entries queued
      drive(0, 0, 64'h0, 32'h0, 0);
      chk("pre_async_count", 64'(count), 64'd2);
      rst = 1'b1;
      #1;
      chk("async_count",     64'(count),     64'd0);
      chk("async_deq_valid", 64'(deq_valid), 64'd0);
      chk("async_enq_ready", 64'(enq_ready), 64'd1);
      chk("async_deq_pc",    deq_pc,         64'd0);
      chk("async_drop_cnt",  64'(drop_cnt),  64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Continuous streaming PC 0..40: occupancy holds at 1 while pointers wrap twice
      drive(0, 1, 64'd0, 32'hC0DE0000, 0);
      chk("stream_prime_count", 64'(count), 64'd0);
      for (int k = 1; k <= 10; k++) begin
         drive(0, 1, 64'(4*k), 32'hC0DE0000 | 32'(4*k), 1);
         chk($sformatf("stream%0d_count", k), 64'(count),     64'd1);
         chk($sformatf("stream%0d_valid", k), 64'(deq_valid), 64'd1);
         chk($sformatf("stream%0d_pc", k),    deq_pc,         64'(4*(k-1)));
         chk($sformatf("stream%0d_instr", k), 64'(deq_instr), 64'(32'hC0DE0000 | 32'(4*(k-1))));
      end
      drive(0, 0, 64'h0, 32'h0, 1);
      chk("stream_last_pc",    deq_pc,         64'd40);
      chk("stream_last_count", 64'(count),     64'd1);
      drive(0, 0, 64'h0, 32'h0, 0);
      chk("stream_end_count",  64'(count),     64'd0);
      chk("stream_end_pc",     deq_pc,         64'd0);

      // Empty-queue latency: zero with bypass, one cycle without
      drive(0, 1, 64'd16, 32'hB4FFFF6B, 1);
`ifdef FETCHQ_BYPASS_EN
      chk("byp_same_valid", 64'(deq_valid), 64'd1);
      chk("byp_same_instr", 64'(deq_instr), 64'hB4FFFF6B);
      chk("byp_same_pc",    deq_pc,         64'd16);
      drive(0, 0, 64'h0, 32'h0, 0);
      chk("byp_next_count", 64'(count),     64'd0);
      chk("byp_next_valid", 64'(deq_valid), 64'd0);
`else
      chk("nobyp_same_valid", 64'(deq_valid), 64'd0);
      chk("nobyp_same_pc",    deq_pc,         64'd0);
      drive(0, 0, 64'h0, 32'h0, 0);
      chk("nobyp_next_valid", 64'(deq_valid), 64'd1);
      chk("nobyp_next_instr", 64'(deq_instr), 64'hB4FFFF6B);
      chk("nobyp_next_count", 64'(count),     64'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
